// File: rtl/avr_tx_arbiter.sv
// avr_tx_arbiter
//   Shares the AVR serial TX channel between two byte-stream requesters
//   (A = bit0, B = bit1) with packet-granular round-robin arbitration.
//   The channel is only used while the cclk detector reports the AVR ready.
//   New bytes are held off while the AVR reports busy. A stuck-busy AVR is
//   handled by a timeout that drops the lock and raises a sticky error.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   cclk_ready            AVR ready from the cclk detector
//   tx_busy               AVR busy; no byte is issued while high
//   a_* / b_*             requester byte streams (data, valid, last, ready)
//   tx_data, new_tx_data  registered byte and one-cycle strobe to the AVR
//   grant                 one-hot current owner (0 = none)
//   timeout_err, err_clr  sticky stuck-busy flag and its clear
module avr_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cclk_ready,
  input  logic                  tx_busy,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_valid,
  input  logic                  a_last,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_valid,
  input  logic                  b_last,
  output logic                  b_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  new_tx_data,
  output logic [1:0]            grant,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {OFFLINE, IDLE, LOCKED, GAP} state_t;

  state_t                         state;
  logic                           ptr;     // round-robin pointer: 0 = A, 1 = B
  logic                           last_q;  // last flag of the byte just accepted
  logic [CNT_W-1:0]               cnt;

  // Requesters gathered into packed arrays so the owner can be indexed.
  logic [1:0]                     req_valid, req_last;
  logic [1:0][DATA_WIDTH-1:0]     req_data;
  logic                           own, own_valid, locked, hs, stall, tmo;

  assign req_valid = {b_valid, a_valid};
  assign req_last  = {b_last, a_last};
  assign req_data  = {b_data, a_data};

  // grant is one-hot while LOCKED, so bit1 alone names the owner.
  assign own       = grant[1];
  assign own_valid = req_valid[own];
  assign locked    = (state == LOCKED);
  assign hs        = locked & own_valid & ~tx_busy & cclk_ready;
  assign stall     = locked & own_valid & tx_busy;
  assign tmo       = stall & cclk_ready & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign a_ready   = hs & grant[0];
  assign b_ready   = hs & grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OFFLINE;
      ptr         <= 1'b0;
      last_q      <= 1'b0;
      cnt         <= '0;
      grant       <= 2'b00;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // hs is only possible in LOCKED, which always steps to GAP, so the
      // strobe can never be high on two consecutive cycles.
      new_tx_data <= hs;
      if (hs) begin
        tx_data <= req_data[own];
        last_q  <= req_last[own];
      end

      // Setting the error has priority over clearing it.
      if (tmo)          timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      if (!cclk_ready) begin
        // AVR went away: abandon any packet and restart arbitration from A.
        state <= OFFLINE;
        grant <= 2'b00;
        ptr   <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          OFFLINE: state <= IDLE;
          IDLE: begin
            cnt <= '0;
            if (a_valid && (!b_valid || !ptr)) begin
              grant <= 2'b01;
              state <= LOCKED;
            end else if (b_valid) begin
              grant <= 2'b10;
              state <= LOCKED;
            end
          end
          LOCKED: begin
            if (hs) begin
              cnt   <= '0;
              state <= GAP;
            end else if (tmo) begin
              // Give up on the stuck byte and hand the channel onward.
              cnt   <= '0;
              state <= IDLE;
              grant <= 2'b00;
              ptr   <= ~own;
            end else if (stall) begin
              cnt <= cnt + CNT_W'(1);
            end else if (!tx_busy) begin
              cnt <= '0;
            end
          end
          GAP: begin
            // One dead cycle covers the AVR's one-cycle busy latency.
            if (last_q) begin
              state <= IDLE;
              grant <= 2'b00;
              ptr   <= ~own;
            end else begin
              state <= LOCKED;
            end
          end
          default: state <= OFFLINE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avr_tx_arbiter.sv
// Directed, table-driven bench for avr_tx_arbiter (TIMEOUT_CYCLES = 16).
// Each table row holds the inputs for one cycle and the outputs expected
// during that cycle; inputs change on the falling edge, outputs are
// sampled 1 ns later, well before the next rising edge.
module tb_avr_tx_arbiter;

  localparam int DW = 8;

  logic          clk, rst_n;
  logic          cclk_ready, tx_busy, err_clr;
  logic [DW-1:0] a_data, b_data, tx_data;
  logic          a_valid, a_last, a_ready;
  logic          b_valid, b_last, b_ready;
  logic          new_tx_data, timeout_err;
  logic [1:0]    grant;

  avr_tx_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cclk_ready(cclk_ready), .tx_busy(tx_busy),
    .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .grant(grant),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit c, bz, clr, av;
    bit [7:0] ad;
    bit al, bv;
    bit [7:0] bd;
    bit bl;
    bit ar, br, nt;
    bit [7:0] td;
    bit [1:0] g;
    bit te;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic v(input bit c, bz, clr, av, input bit [7:0] ad, input bit al,
                   input bit bv, input bit [7:0] bd, input bit bl,
                   input bit ar, br, nt, input bit [7:0] td, input bit [1:0] g,
                   input bit te);
    vec_t x;
    x.c = c; x.bz = bz; x.clr = clr; x.av = av; x.ad = ad; x.al = al;
    x.bv = bv; x.bd = bd; x.bl = bl;
    x.ar = ar; x.br = br; x.nt = nt; x.td = td; x.g = g; x.te = te;
    vecs.push_back(x);
  endtask

  // Packed view: {a_ready, b_ready, new_tx_data, tx_data, grant, timeout_err}
  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: ar/br/nt/td/g/te got %b/%b/%b/%h/%b/%b expected %b/%b/%b/%h/%b/%b",
               name, act[13], act[12], act[11], act[10:3], act[2:1], act[0],
               exp[13], exp[12], exp[11], exp[10:3], exp[2:1], exp[0]);
    end
  endtask

  function automatic logic [13:0] outs();
    return {a_ready, b_ready, new_tx_data, tx_data, grant, timeout_err};
  endfunction

  initial begin
    //  c bz clr av ad    al bv bd    bl   ar br nt td    g      te
    // enable: cclk low blocks everything, then OFFLINE -> IDLE -> LOCKED
    v(0,0,0, 1,8'h11,0, 0,8'h00,0,  0,0,0,8'h00,2'b00,0);
    v(0,0,0, 1,8'h11,0, 0,8'h00,0,  0,0,0,8'h00,2'b00,0);
    v(1,0,0, 1,8'h11,0, 0,8'h00,0,  0,0,0,8'h00,2'b00,0);
    v(1,0,0, 1,8'h11,0, 0,8'h00,0,  0,0,0,8'h00,2'b00,0);
    // single packet 11,22,33
    v(1,0,0, 1,8'h11,0, 0,8'h00,0,  1,0,0,8'h00,2'b01,0);
    v(1,0,0, 1,8'h22,0, 0,8'h00,0,  0,0,1,8'h11,2'b01,0);
    v(1,0,0, 1,8'h22,0, 0,8'h00,0,  1,0,0,8'h11,2'b01,0);
    v(1,0,0, 1,8'h33,1, 0,8'h00,0,  0,0,1,8'h22,2'b01,0);
    v(1,0,0, 1,8'h33,1, 0,8'h00,0,  1,0,0,8'h22,2'b01,0);
    v(1,0,0, 0,8'h00,0, 0,8'h00,0,  0,0,1,8'h33,2'b01,0);
    v(1,0,0, 0,8'h00,0, 0,8'h00,0,  0,0,0,8'h33,2'b00,0);
    // busy throttle: 10 busy cycles, no strobe, no error
    v(1,0,0, 1,8'h44,0, 0,8'h00,0,  0,0,0,8'h33,2'b00,0);
    for (int i = 0; i < 10; i++)
      v(1,1,0, 1,8'h44,0, 0,8'h00,0,  0,0,0,8'h33,2'b01,0);
    v(1,0,0, 1,8'h44,0, 0,8'h00,0,  1,0,0,8'h33,2'b01,0);
    v(1,0,0, 1,8'h55,1, 0,8'h00,0,  0,0,1,8'h44,2'b01,0);
    v(1,0,0, 1,8'h55,1, 0,8'h00,0,  1,0,0,8'h44,2'b01,0);
    v(1,0,0, 0,8'h00,0, 0,8'h00,0,  0,0,1,8'h55,2'b01,0);
    v(1,0,0, 0,8'h00,0, 0,8'h00,0,  0,0,0,8'h55,2'b00,0);
    // cclk drop resets the pointer (was B) to A; then contention A,B,A
    v(0,0,0, 0,8'h00,0, 0,8'h00,0,  0,0,0,8'h55,2'b00,0);
    v(1,0,0, 1,8'hA1,0, 1,8'hB1,0,  0,0,0,8'h55,2'b00,0);
    v(1,0,0, 1,8'hA1,0, 1,8'hB1,0,  0,0,0,8'h55,2'b00,0);
    v(1,0,0, 1,8'hA1,0, 1,8'hB1,0,  1,0,0,8'h55,2'b01,0);
    v(1,0,0, 1,8'hA2,1, 1,8'hB1,0,  0,0,1,8'hA1,2'b01,0);
    v(1,0,0, 1,8'hA2,1, 1,8'hB1,0,  1,0,0,8'hA1,2'b01,0);
    v(1,0,0, 1,8'hA3,0, 1,8'hB1,0,  0,0,1,8'hA2,2'b01,0);
    v(1,0,0, 1,8'hA3,0, 1,8'hB1,0,  0,0,0,8'hA2,2'b00,0);
    v(1,0,0, 1,8'hA3,0, 1,8'hB1,0,  0,1,0,8'hA2,2'b10,0);
    v(1,0,0, 1,8'hA3,0, 1,8'hB2,1,  0,0,1,8'hB1,2'b10,0);
    v(1,0,0, 1,8'hA3,0, 1,8'hB2,1,  0,1,0,8'hB1,2'b10,0);
    v(1,0,0, 1,8'hA3,0, 0,8'h00,0,  0,0,1,8'hB2,2'b10,0);
    v(1,0,0, 1,8'hA3,0, 0,8'h00,0,  0,0,0,8'hB2,2'b00,0);
    v(1,0,0, 1,8'hA3,0, 0,8'h00,0,  1,0,0,8'hB2,2'b01,0);
    v(1,0,0, 1,8'hA4,1, 0,8'h00,0,  0,0,1,8'hA3,2'b01,0);
    v(1,0,0, 1,8'hA4,1, 0,8'h00,0,  1,0,0,8'hA3,2'b01,0);
    v(1,0,0, 0,8'h00,0, 0,8'h00,0,  0,0,1,8'hA4,2'b01,0);
    v(1,0,0, 0,8'h00,0, 0,8'h00,0,  0,0,0,8'hA4,2'b00,0);
    // timeout: A locked with busy stuck; B waits; clear in the set cycle loses
    v(1,1,0, 1,8'hC1,0, 0,8'h00,0,  0,0,0,8'hA4,2'b00,0);
    for (int i = 0; i < 15; i++)
      v(1,1,0, 1,8'hC1,0, 1,8'hD1,1,  0,0,0,8'hA4,2'b01,0);
    v(1,1,1, 1,8'hC1,0, 1,8'hD1,1,  0,0,0,8'hA4,2'b01,0);
    v(1,1,0, 1,8'hC1,0, 1,8'hD1,1,  0,0,0,8'hA4,2'b00,1);
    v(1,0,1, 1,8'hC1,0, 1,8'hD1,1,  0,1,0,8'hA4,2'b10,1);
    v(1,0,0, 1,8'hC1,0, 0,8'h00,0,  0,0,1,8'hD1,2'b10,0);
    v(1,0,0, 1,8'hC1,0, 0,8'h00,0,  0,0,0,8'hD1,2'b00,0);
    // cclk drop after byte 1 of 3
    v(1,0,0, 1,8'hE1,0, 0,8'h00,0,  1,0,0,8'hD1,2'b01,0);
    v(1,0,0, 1,8'hE2,0, 0,8'h00,0,  0,0,1,8'hE1,2'b01,0);
    v(0,0,0, 1,8'hE2,0, 0,8'h00,0,  0,0,0,8'hE1,2'b01,0);
    v(0,0,0, 1,8'hE2,0, 0,8'h00,0,  0,0,0,8'hE1,2'b00,0);
    v(1,0,0, 1,8'hE1,0, 1,8'hF1,1,  0,0,0,8'hE1,2'b00,0);
    v(1,0,0, 1,8'hE1,0, 1,8'hF1,1,  0,0,0,8'hE1,2'b00,0);
    v(1,0,0, 1,8'hE1,0, 1,8'hF1,1,  1,0,0,8'hE1,2'b01,0);
    v(1,0,0, 0,8'h00,0, 1,8'hF1,1,  0,0,1,8'hE1,2'b01,0);
    // owner drops valid mid-packet with busy high: lock held, no timeout
    for (int i = 0; i < 20; i++)
      v(1,1,0, 0,8'h00,0, 1,8'hF1,1,  0,0,0,8'hE1,2'b01,0);
    v(1,0,0, 1,8'hE2,1, 1,8'hF1,1,  1,0,0,8'hE1,2'b01,0);
    v(1,0,0, 0,8'h00,0, 1,8'hF1,1,  0,0,1,8'hE2,2'b01,0);
    v(1,0,0, 0,8'h00,0, 1,8'hF1,1,  0,0,0,8'hE2,2'b00,0);
    v(1,0,0, 0,8'h00,0, 1,8'hF1,1,  0,1,0,8'hE2,2'b10,0);

    // reset state
    rst_n = 1'b0; cclk_ready = 1'b0; tx_busy = 1'b0; err_clr = 1'b0;
    a_data = '0; a_valid = 1'b0; a_last = 1'b0;
    b_data = '0; b_valid = 1'b0; b_last = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset", outs(), 14'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      cclk_ready = vecs[i].c;  tx_busy = vecs[i].bz; err_clr = vecs[i].clr;
      a_valid = vecs[i].av; a_data = vecs[i].ad; a_last = vecs[i].al;
      b_valid = vecs[i].bv; b_data = vecs[i].bd; b_last = vecs[i].bl;
      #1;
      chk($sformatf("vec%0d", i), outs(),
          {vecs[i].ar, vecs[i].br, vecs[i].nt, vecs[i].td, vecs[i].g, vecs[i].te});
    end

    // asynchronous reset in the middle of B's handshake cycle
    #1 rst_n = 1'b0;
    #1 chk("async_reset", outs(), 14'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cclk_ready = 1'b0; b_valid = 1'b0;
    @(negedge clk); #1;
    chk("post_reset", outs(), 14'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
